// File: rtl/sha_1_pad_pkg.sv
// sha_const: padder state encoding and block geometry shared by the SHA-1 message formatter.
package sha_const;
    typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT, PAD} pad_state_t;
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam int BLOCK_W = 512;
    localparam int WORDS = 16;
endpackage

// File: rtl/sha_1_pad_word.sv
// sha_1_pad_word: masks the final message word and inserts the 0x80 pad byte after its valid bytes.
// SHA_1_PAD_BYTE_EN undefined: every final word is full, so the pad byte always moves to the next slot.
module sha_1_pad_word (
    input  logic [31:0] word,
`ifdef SHA_1_PAD_BYTE_EN
    input  logic [2:0]  bytes,
`endif
    output logic [31:0] padded,
    output logic        carry
);
`ifdef SHA_1_PAD_BYTE_EN
    always_comb begin
        padded = bytes == 3'd1 ? {word[31:24], 24'h80_0000} :
                 bytes == 3'd2 ? {word[31:16], 16'h8000} :
                 bytes == 3'd3 ? {word[31:8], 8'h80} : word;
        carry = !(bytes inside {3'd1, 3'd2, 3'd3});
    end
`else
    assign padded = word;
    assign carry = 1'b1;
`endif
endmodule

// File: rtl/sha_1_pad.sv
// sha_1_pad: FIPS 180-4 padder packing a 32-bit word stream into 512-bit blocks for the SHA-1 core.
// SHA_1_PAD_BYTE_EN adds in_bytes for byte-granular message lengths.
module sha_1_pad
    import sha_const::*;
(
    input  logic           rst,
    input  logic           clk,
    input  logic [31:0]    in_data,
    input  logic           in_valid,
    input  logic           in_last,
`ifdef SHA_1_PAD_BYTE_EN
    input  logic [2:0]     in_bytes,
`endif
    output logic           in_ready,
    output logic [BLOCK_W-1:0] Data,
    output logic [63:0]    Index,
    output logic           Enable,
    input  logic           Ready,
    output logic           msg_done
);
    pad_state_t state, state_nx;
    logic [31:0] blk [WORDS];
    logic [31:0] blk_last [WORDS];
    logic [3:0]  wcnt;
    logic [60:0] len, len_nx;
    logic [2:0]  nbytes;
    logic [31:0] word_pad;
    logic [4:0]  pad_slot;
    logic [63:0] bit_len, bit_len_nx;
    logic        fin, pend, lead, carry, fits, accept;

`ifdef SHA_1_PAD_BYTE_EN
    assign nbytes = in_bytes inside {3'd1, 3'd2, 3'd3} ? in_bytes : 3'd4;
    sha_1_pad_word u_word (.word(in_data), .bytes(nbytes), .padded(word_pad), .carry(carry));
`else
    assign nbytes = 3'd4;
    sha_1_pad_word u_word (.word(in_data), .padded(word_pad), .carry(carry));
`endif

    assign accept = in_valid && in_ready;
    assign len_nx = len + 61'(nbytes);
    assign bit_len_nx = {len_nx, 3'b000};
    assign bit_len = {len, 3'b000};
    assign pad_slot = {1'b0, wcnt} + {4'b0000, carry};
    assign fits = pad_slot <= 5'd13;

    for (genvar g = 0; g < WORDS; g++) begin : g_data
        assign Data[g*32 +: 32] = blk[g];
    end

    // Final-word image of the whole block: data kept below the last slot, pad after, length if it fits.
    always_comb begin
        for (int i = 0; i < WORDS; i++)
            blk_last[i] = 5'(i) < {1'b0, wcnt} ? blk[i] :
                          5'(i) == {1'b0, wcnt} ? word_pad :
                          (carry && 5'(i) == pad_slot) ? PAD_WORD : '0;
        if (fits) begin
            blk_last[14] = bit_len_nx[63:32];
            blk_last[15] = bit_len_nx[31:0];
        end
    end

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        in_ready = rst && (state == IDLE || state == FILL);
        Enable = rst && state == SEND;
        msg_done = rst && state == WAIT && Ready && fin;
        unique case (state)
            IDLE, FILL: state_nx = !accept ? state : (in_last || wcnt == 4'd15) ? SEND : FILL;
            SEND:       state_nx = WAIT;
            WAIT:       state_nx = !Ready ? WAIT : fin ? IDLE : pend ? PAD : FILL;
            PAD:        state_nx = SEND;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) blk[i] <= '0;
            wcnt <= '0;
            len <= '0;
            Index <= '0;
            fin <= 1'b0;
            pend <= 1'b0;
            lead <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) Index <= 64'd1;
            wcnt <= wcnt + 4'd1;
            len <= len_nx;
            if (in_last) begin
                for (int i = 0; i < WORDS; i++) blk[i] <= blk_last[i];
                fin <= fits;
                pend <= !fits;
                lead <= carry && wcnt == 4'd15;
            end else begin
                blk[wcnt] <= in_data;
            end
        end else if (state == WAIT && Ready) begin
            wcnt <= '0;
            if (fin) begin
                Index <= '0;
                len <= '0;
                fin <= 1'b0;
            end else if (!pend) begin
                Index <= Index + 64'd1;
            end
        end else if (state == PAD) begin
            // Length-only block; carries the lead pad word when the data ended exactly on a block edge.
            for (int i = 0; i < WORDS; i++) blk[i] <= '0;
            blk[0] <= lead ? PAD_WORD : '0;
            blk[14] <= bit_len[63:32];
            blk[15] <= bit_len[31:0];
            Index <= Index + 64'd1;
            fin <= 1'b1;
            pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sha_1_pad.sv
// tb_sha_1_pad: directed and random messages checked against a byte-level padding model and a SHA-1 model.
module tb_sha_1_pad;
    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] in_data = '0;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic [2:0] in_bytes = 3'd4;
    logic in_ready, Enable, msg_done;
    logic Ready = 1'b0;
    logic [511:0] Data;
    logic [63:0] Index;
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;
    logic [511:0] got_d[$];
    logic [63:0] got_i[$];
    int got_c[$], rdy_c[$];
    logic [7:0] msg[$];

    sha_1_pad dut (
        .rst(rst), .clk(clk), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
`ifdef SHA_1_PAD_BYTE_EN
        .in_bytes(in_bytes),
`endif
        .in_ready(in_ready), .Data(Data), .Index(Index), .Enable(Enable), .Ready(Ready),
        .msg_done(msg_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] sha1(input logic [511:0] blks[$]);
        logic [31:0] h0 = 32'h67452301, h1 = 32'hefcdab89, h2 = 32'h98badcfe;
        logic [31:0] h3 = 32'h10325476, h4 = 32'hc3d2e1f0;
        logic [31:0] w[80];
        logic [31:0] a, b, c, d, e, f, k, t;
        foreach (blks[n]) begin
            for (int i = 0; i < 16; i++) w[i] = blks[n][i*32 +: 32];
            for (int i = 16; i < 80; i++) begin
                t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
                w[i] = {t[30:0], t[31]};
            end
            a = h0; b = h1; c = h2; d = h3; e = h4;
            for (int i = 0; i < 80; i++) begin
                if (i < 20) begin f = (b & c) | (~b & d); k = 32'h5a827999; end
                else if (i < 40) begin f = b ^ c ^ d; k = 32'h6ed9eba1; end
                else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
                else begin f = b ^ c ^ d; k = 32'hca62c1d6; end
                t = {a[26:0], a[31:27]} + f + e + k + w[i];
                e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
            end
            h0 += a; h1 += b; h2 += c; h3 += d; h4 += e;
        end
        return {h0, h1, h2, h3, h4};
    endfunction

    // Core stand-in: captures each block on Enable and answers with Ready a few cycles later.
    initial forever begin
        @(negedge clk);
        if (Enable === 1'b1) begin
            logic [511:0] d;
            d = Data;
            got_d.push_back(Data);
            got_i.push_back(Index);
            got_c.push_back(cyc);
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                chk("enable_one_cycle", 512'(Enable), 0);
                chk("in_ready_wait", 512'(in_ready), 0);
                chk("data_stable", Data, d);
                chk("index_stable", 512'(Index), 512'(got_i[$]));
            end
            Ready = 1'b1;
            rdy_c.push_back(cyc);
            #1;
            chk("in_ready_ready", 512'(in_ready), 0);
            if (msg_done === 1'b1) done_cnt++;
            @(negedge clk);
            Ready = 1'b0;
        end
    end

    task automatic put_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                            input logic exp_en, input bit hold);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("accept_timeout", 512'(t < 200), 1);
        @(negedge clk);
        chk("enable_after_word", 512'(Enable), 512'(exp_en));
        if (!hold) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic run_msg(input bit hold, input int bad, input string name);
        logic [7:0] p[$];
        logic [511:0] exp_b[$];
        logic [63:0] bl;
        int nw, t, m;
        p = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        for (int k = 0; k < p.size() / 64; k++) begin
            logic [511:0] v;
            for (int i = 0; i < 16; i++)
                v[i*32 +: 32] = {p[k*64+i*4], p[k*64+i*4+1], p[k*64+i*4+2], p[k*64+i*4+3]};
            exp_b.push_back(v);
        end
        got_d.delete(); got_i.delete(); got_c.delete(); rdy_c.delete();
        done_cnt = 0;
        nw = (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int nb;
            d = '0;
            nb = (msg.size() - w*4 < 4) ? msg.size() - w*4 : 4;
            for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[w*4+j];
            put_word(d, w == nw-1, (w == nw-1 && nb == 4 && bad >= 0) ? 3'(bad) : 3'(nb),
                     w == nw-1 || w % 16 == 15, hold);
        end
        in_valid = 1'b0; in_last = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk({name, "_done"}, 512'(done_cnt), 1);
        chk({name, "_nblk"}, 512'(got_d.size()), 512'(exp_b.size()));
        for (int k = 0; k < exp_b.size() && k < got_d.size(); k++) begin
            chk({name, "_data"}, got_d[k], exp_b[k]);
            chk({name, "_index"}, 512'(got_i[k]), 512'(k + 1));
        end
        m = msg.size() % 64;
        if ((m == 0 || m >= 56) && got_d.size() >= 2 && rdy_c.size() >= got_d.size())
            chk({name, "_pad_latency"}, 512'(got_c[got_d.size()-1] - rdy_c[got_d.size()-2]), 2);
        chk({name, "_idle_index"}, 512'(Index), 0);
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    initial begin
        string s;
        int lens[9] = '{52, 55, 56, 60, 63, 64, 68, 120, 128};
        repeat (3) @(negedge clk);
        chk("rst_enable", 512'(Enable), 0);
        chk("rst_msg_done", 512'(msg_done), 0);
        chk("rst_index", 512'(Index), 0);
        chk("rst_data", Data, 0);
        chk("rst_in_ready", 512'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 512'(in_ready), 1);
`ifdef SHA_1_PAD_BYTE_EN
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(0, -1, "abc");
        chk("abc_hash", 512'(sha1(got_d)), 512'(160'ha9993e364706816aba3e25717850c26c9cd0d89d));
`endif
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        run_msg(0, -1, "msg56");
        chk("msg56_hash", 512'(sha1(got_d)), 512'(160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1));
        foreach (lens[i]) begin
`ifndef SHA_1_PAD_BYTE_EN
            if (lens[i] % 4 != 0) continue;
`endif
            rand_msg(lens[i]);
            run_msg(0, -1, "boundary");
        end
        rand_msg(64);
        run_msg(1, -1, "hold64");
        rand_msg(140);
        run_msg(1, -1, "hold140");
        for (int w = 0; w < 5; w++) put_word($urandom, 1'b0, 3'd4, 1'b0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_index", 512'(Index), 0);
        chk("midrst_data", Data, 0);
        chk("midrst_in_ready", 512'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
`ifdef SHA_1_PAD_BYTE_EN
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(0, -1, "abc_after_rst");
        chk("abc_after_rst_hash", 512'(sha1(got_d)), 512'(160'ha9993e364706816aba3e25717850c26c9cd0d89d));
        rand_msg(8);
        run_msg(0, 0, "bytes0");
        rand_msg(12);
        run_msg(0, $urandom_range(5, 7), "bytes_hi");
`else
        msg = '{8'h61, 8'h62, 8'h63, 8'h64};
        run_msg(0, -1, "abcd_after_rst");
`endif
        for (int n = 0; n < 12; n++) begin
`ifdef SHA_1_PAD_BYTE_EN
            rand_msg($urandom_range(1, 200));
`else
            rand_msg(4 * $urandom_range(1, 50));
`endif
            run_msg(n % 3 == 0, -1, "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
